// File: rtl/des_nic_output_control_unit.sv
// Output sequencer for the DES NiC. It captures the PE result, sends it to the router as a
// header / data-high / data-low packet, and counts credits for the downstream router buffer.
module des_nic_output_control_unit #(
  parameter int CHANNEL_WIDTH = 32,
  parameter int PACKET_FLITS  = 3,
  parameter int BUFFER_DEPTH  = 5,
  parameter int CREDIT_WIDTH  = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       done_strobe_din,
  input  logic [2*CHANNEL_WIDTH-1:0] ciphertext_din,
  input  logic [CHANNEL_WIDTH-3:0]   header_flit_din,
  input  logic                       credit_in_din,
  output logic [CHANNEL_WIDTH-1:0]   output_channel_dout,
  output logic                       zero_credits_dout,
  output logic                       busy_dout
);

  localparam int FIDX_W = $clog2(PACKET_FLITS);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  localparam logic [FIDX_W-1:0]       LAST_IDX   = FIDX_W'(PACKET_FLITS - 1);
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(BUFFER_DEPTH);
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_PKT = CREDIT_WIDTH'(PACKET_FLITS);

  typedef struct packed {
    logic [CHANNEL_WIDTH-3:0]   hdr;
    logic [2*CHANNEL_WIDTH-1:0] ct;
  } pkt_t;

  logic [0:0]              state;
  logic [FIDX_W-1:0]       flit_idx;
  logic [CREDIT_WIDTH-1:0] credit_count;
  pkt_t                    pkt;
  logic                    send, last, accept;
  logic [CHANNEL_WIDTH-1:0] flit;

  // A done strobe on the edge that loads the last flit starts the next packet back-to-back.
  always_comb begin
    send   = (state == SEND) && (credit_count != '0);
    last   = send && (flit_idx == LAST_IDX);
    accept = done_strobe_din && ((state == IDLE) || last);
    case (flit_idx)
      FIDX_W'(0): flit = {2'b11, pkt.hdr};
      FIDX_W'(1): flit = pkt.ct[2*CHANNEL_WIDTH-1:CHANNEL_WIDTH];
      default:    flit = pkt.ct[CHANNEL_WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      flit_idx            <= '0;
      credit_count        <= CREDIT_MAX;
      pkt                 <= '0;
      output_channel_dout <= '0;
    end else begin
      if (accept) begin
        pkt.hdr <= header_flit_din;
        pkt.ct  <= ciphertext_din;
      end

      if (accept)    state <= SEND;
      else if (last) state <= IDLE;

      if (accept || last) flit_idx <= '0;
      else if (send)      flit_idx <= flit_idx + 1'b1;

      output_channel_dout <= send ? flit : '0;

      // Return saturates at full depth; a return on a send edge nets to zero.
      if (send && !credit_in_din)
        credit_count <= credit_count - 1'b1;
      else if (credit_in_din && !send && credit_count != CREDIT_MAX)
        credit_count <= credit_count + 1'b1;
    end
  end

  assign busy_dout         = (state == SEND);
  assign zero_credits_dout = (credit_count < CREDIT_PKT);

endmodule

// File: tb/tb_des_nic_output_control_unit.sv
// Directed bench for des_nic_output_control_unit: a vector table for reset, single-packet and
// stall cases, followed by hand-written sequences for credits, back-to-back and mid-packet reset.
module tb_des_nic_output_control_unit;

  logic        clk = 1'b0;
  logic        reset, done_strobe_din, credit_in_din;
  logic [63:0] ciphertext_din;
  logic [29:0] header_flit_din;
  logic [31:0] output_channel_dout;
  logic        zero_credits_dout, busy_dout;

  int errors = 0;
  int checks = 0;

  des_nic_output_control_unit dut (
    .clk                 (clk),
    .reset               (reset),
    .done_strobe_din     (done_strobe_din),
    .ciphertext_din      (ciphertext_din),
    .header_flit_din     (header_flit_din),
    .credit_in_din       (credit_in_din),
    .output_channel_dout (output_channel_dout),
    .zero_credits_dout   (zero_credits_dout),
    .busy_dout           (busy_dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst, done, cin;
    logic [29:0] hdr;
    logic [63:0] ct;
    logic [31:0] eo;
    logic        eb, ez;
    logic [2:0]  ec;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string name, logic rst, logic done, logic cin, logic [29:0] hdr,
                              logic [63:0] ct, logic [31:0] eo, logic eb, logic ez, logic [2:0] ec);
    vec_t v;
    v.name = name; v.rst = rst; v.done = done; v.cin = cin; v.hdr = hdr; v.ct = ct;
    v.eo = eo; v.eb = eb; v.ez = ez; v.ec = ec;
    vecs.push_back(v);
  endfunction

  // Drive inputs for one edge, then sample 1ns after it.
  task automatic step(input logic rst, input logic done, input logic cin,
                      input logic [29:0] hdr, input logic [63:0] ct);
    @(negedge clk);
    reset = rst; done_strobe_din = done; credit_in_din = cin;
    header_flit_din = hdr; ciphertext_din = ct;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string name, input logic [31:0] eo, input logic eb,
                            input logic ez, input logic [2:0] ec);
    checks += 4;
    if (output_channel_dout !== eo) begin
      errors++;
      $display("FAIL %s out: got %h want %h", name, output_channel_dout, eo);
    end
    if (busy_dout !== eb) begin
      errors++;
      $display("FAIL %s busy: got %b want %b", name, busy_dout, eb);
    end
    if (zero_credits_dout !== ez) begin
      errors++;
      $display("FAIL %s zero_credits: got %b want %b", name, zero_credits_dout, ez);
    end
    if (dut.credit_count !== ec) begin
      errors++;
      $display("FAIL %s credit_count: got %0d want %0d", name, dut.credit_count, ec);
    end
  endtask

  initial begin
    reset = 1'b1; done_strobe_din = 1'b0; credit_in_din = 1'b0;
    header_flit_din = '0; ciphertext_din = '0;

    // T1 reset
    add("t1_rst0", 1, 0, 0, 30'h0, 64'h0, 32'h0, 0, 0, 3'd5);
    add("t1_rst1", 1, 0, 0, 30'h0, 64'h0, 32'h0, 0, 0, 3'd5);
    // T2 single packet
    add("t2_e0", 0, 1, 0, 30'h0000_0123, 64'hDEADBEEF_01234567, 32'h0, 1, 0, 3'd5);
    add("t2_hdr", 0, 0, 0, 30'h0, 64'h0, 32'hC0000123, 1, 0, 3'd4);
    add("t2_hi",  0, 0, 0, 30'h0, 64'h0, 32'hDEADBEEF, 1, 0, 3'd3);
    add("t2_lo",  0, 0, 0, 30'h0, 64'h0, 32'h01234567, 0, 1, 3'd2);
    add("t2_idle",0, 0, 0, 30'h0, 64'h0, 32'h0,        0, 1, 3'd2);
    // T3 credit stall
    add("t3_e0", 0, 1, 0, 30'h1234_5678, 64'hCAFEF00D_8BADF00D, 32'h0, 1, 1, 3'd2);
    add("t3_hdr",  0, 0, 0, 30'h0, 64'h0, 32'hD2345678, 1, 1, 3'd1);
    add("t3_hi",   0, 0, 0, 30'h0, 64'h0, 32'hCAFEF00D, 1, 1, 3'd0);
    add("t3_stl0", 0, 0, 0, 30'h0, 64'h0, 32'h0,        1, 1, 3'd0);
    add("t3_stl1", 0, 0, 0, 30'h0, 64'h0, 32'h0,        1, 1, 3'd0);
    add("t3_cin",  0, 0, 1, 30'h0, 64'h0, 32'h0,        1, 1, 3'd1);
    add("t3_lo",   0, 0, 0, 30'h0, 64'h0, 32'h8BADF00D, 0, 1, 3'd0);
    add("t3_idle", 0, 0, 0, 30'h0, 64'h0, 32'h0,        0, 1, 3'd0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].done, vecs[i].cin, vecs[i].hdr, vecs[i].ct);
      expect_all(vecs[i].name, vecs[i].eo, vecs[i].eb, vecs[i].ez, vecs[i].ec);
    end

    // T4 credit returns, saturation, and return coinciding with a send
    for (int i = 0; i < 5; i++) step(0, 0, 1, 30'h0, 64'h0);
    expect_all("t4_refill", 32'h0, 0, 0, 3'd5);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 30'h0, 64'h0);
      expect_all("t4_sat", 32'h0, 0, 0, 3'd5);
    end
    step(0, 1, 0, 30'h0, 64'h11111111_22222222);
    expect_all("t4_e0", 32'h0, 1, 0, 3'd5);
    step(0, 0, 1, 30'h0, 64'h0);
    expect_all("t4_hdr_cin", 32'hC0000000, 1, 0, 3'd5);
    step(0, 0, 0, 30'h0, 64'h0);
    expect_all("t4_hi", 32'h11111111, 1, 0, 3'd4);
    step(0, 0, 0, 30'h0, 64'h0);
    expect_all("t4_lo", 32'h22222222, 0, 0, 3'd3);

    // T5 back-to-back: second done on the edge that sends the first packet's data-low
    step(0, 0, 1, 30'h0, 64'h0);
    step(0, 0, 1, 30'h0, 64'h0);
    expect_all("t5_refill", 32'h0, 0, 0, 3'd5);
    step(0, 1, 0, 30'h0AA, 64'hA1A1A1A1_A2A2A2A2);
    step(0, 0, 0, 30'h0, 64'h0);
    expect_all("t5_a_hdr", 32'hC00000AA, 1, 0, 3'd4);
    step(0, 0, 0, 30'h0, 64'h0);
    step(0, 1, 0, 30'h0BB, 64'hB1B1B1B1_B2B2B2B2);
    expect_all("t5_a_lo", 32'hA2A2A2A2, 1, 1, 3'd2);
    step(0, 0, 0, 30'h0, 64'h0);
    expect_all("t5_b_hdr", 32'hC00000BB, 1, 1, 3'd1);
    step(0, 0, 0, 30'h0, 64'h0);
    expect_all("t5_b_hi", 32'hB1B1B1B1, 1, 1, 3'd0);
    step(0, 0, 0, 30'h0, 64'h0);
    expect_all("t5_b_stall", 32'h0, 1, 1, 3'd0);
    step(0, 0, 1, 30'h0, 64'h0);
    step(0, 0, 0, 30'h0, 64'h0);
    expect_all("t5_b_lo", 32'hB2B2B2B2, 0, 1, 3'd0);

    // T6 reset after the header leaves: no further flits, full credits
    for (int i = 0; i < 5; i++) step(0, 0, 1, 30'h0, 64'h0);
    step(0, 1, 0, 30'h0CC, 64'h33333333_44444444);
    step(0, 0, 0, 30'h0, 64'h0);
    expect_all("t6_hdr", 32'hC00000CC, 1, 0, 3'd4);
    step(1, 0, 0, 30'h0, 64'h0);
    expect_all("t6_rst", 32'h0, 0, 0, 3'd5);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 30'h0, 64'h0);
      expect_all("t6_quiet", 32'h0, 0, 0, 3'd5);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
